// File: rtl/instr_reg_fifo_if.sv
// rtl/instr_reg_fifo_if.sv - fetch/decode handshake bundle for the tagged instruction FIFO
interface instr_reg_fifo_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 2,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [TAG_W-1:0] phase;
    logic             flush;
    logic [WIDTH-1:0] out_instr;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] count;
    logic             tag_err;

    modport master (
        output in_data, in_valid, phase, flush, out_ready,
        input  in_ready, out_instr, out_valid, count, tag_err
    );

    modport slave (
        input  in_data, in_valid, phase, flush, out_ready,
        output in_ready, out_instr, out_valid, count, tag_err
    );
endinterface

// File: rtl/instr_reg_fifo.sv
// rtl/instr_reg_fifo.sv - phase-tagged instruction FIFO; optional zero-latency path via INSTR_REG_FALLTHROUGH_EN
module instr_reg_fifo #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 2,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    instr_reg_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             tag_err_q;

    logic match;
    logic full;
    logic empty;
    logic hs;
    logic bypass;
    logic push;
    logic pop;
    logic drop;

    always_comb begin
        match = (bus.in_data[WIDTH-1 -: TAG_W] == bus.phase);
        full  = (cnt == CNT_W'(DEPTH));
        empty = (cnt == '0);
        hs    = bus.in_valid && !full;
`ifdef INSTR_REG_FALLTHROUGH_EN
        // A matching word arriving at an empty FIFO that decode takes right away never touches memory.
        bypass = empty && bus.in_valid && match && bus.out_ready;
`else
        bypass = 1'b0;
`endif
        push = hs && match && !bypass && !bus.flush;
        pop  = !empty && bus.out_ready && !bus.flush;
        drop = hs && !match && !bus.flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            cnt       <= '0;
            tag_err_q <= 1'b0;
        end else if (bus.flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            cnt       <= '0;
            tag_err_q <= 1'b0;
        end else begin
            tag_err_q <= drop;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_comb begin
        bus.in_ready = !full;
        bus.count    = cnt;
        bus.tag_err  = tag_err_q;
        bus.out_valid = !empty;
        bus.out_instr = empty ? '0 : mem[rd_ptr];
`ifdef INSTR_REG_FALLTHROUGH_EN
        if (empty && bus.in_valid && match) begin
            bus.out_valid = 1'b1;
            bus.out_instr = bus.in_data;
        end
`endif
    end
endmodule

// File: tb/tb_instr_reg_fifo.sv
// tb/tb_instr_reg_fifo.sv - scoreboard bench for instr_reg_fifo
module tb_instr_reg_fifo;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [15:0] sb [$];

    instr_reg_fifo_if #(.WIDTH(16), .TAG_W(2), .DEPTH(4)) bus ();

    instr_reg_fifo #(.WIDTH(16), .TAG_W(2), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; the expected word is queued when the handshake completes.
    task automatic cyc(input logic v, input logic [15:0] d, input logic ordy, input logic fl);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.flush     = fl;
        @(negedge clk);
        if (fl) sb.delete();
        else if (v && bus.in_ready && d[15:14] == bus.phase) sb.push_back(d);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && bus.out_valid && bus.out_ready && !bus.flush) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pop", {16'h0, bus.out_instr}, 32'hDEAD_BEEF);
                end else begin
                    chk("pop_data", {16'h0, bus.out_instr}, {16'h0, sb.pop_front()});
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        bus.flush = 1'b0;
        bus.phase = 2'b01;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", bus.count, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_instr", bus.out_instr, 0);
        chk("rst_tag_err", bus.tag_err, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);

        // first push, one-cycle latency
        cyc(1, 16'h4001, 0, 0);
        chk("t1_out_valid", bus.out_valid, 1);
        chk("t1_out_instr", bus.out_instr, 16'h4001);
        chk("t1_count", bus.count, 1);
        chk("t1_tag_err", bus.tag_err, 0);

        // tag mismatch is dropped with a single-cycle tag_err
        cyc(1, 16'h8123, 0, 0);
        chk("t2_count", bus.count, 1);
        chk("t2_tag_err", bus.tag_err, 1);
        chk("t2_in_ready", bus.in_ready, 1);
        cyc(0, 16'h0, 1, 0);
        chk("t2_tag_err_clear", bus.tag_err, 0);
        chk("t2_count_drain", bus.count, 0);

        // fill to full, fifth word held upstream
        for (int i = 0; i < 4; i++) begin
            cyc(1, 16'h4010 + 16'(i), 0, 0);
            chk("t3_fill_count", bus.count, i + 1);
        end
        chk("t3_full_in_ready", bus.in_ready, 0);
        cyc(1, 16'h4014, 0, 0);
        chk("t3_held_count", bus.count, 4);
        cyc(1, 16'h4014, 1, 0);
        chk("t3_pop_full_count", bus.count, 3);
        cyc(1, 16'h4014, 1, 0);
        chk("t3_push_pop_count", bus.count, 3);
        repeat (3) cyc(0, 16'h0, 1, 0);
        chk("t3_drained", bus.count, 0);

        // simultaneous push/pop at count 2, then pointer wrap
        cyc(1, 16'h4020, 0, 0);
        cyc(1, 16'h4021, 0, 0);
        cyc(1, 16'h4022, 1, 0);
        chk("t4_count_hold", bus.count, 2);
        for (int i = 0; i < 12; i++) begin
            cyc(1, 16'h4030 + 16'(i), 1, 0);
            chk("t4_wrap_count", bus.count, 2);
        end
        repeat (2) cyc(0, 16'h0, 1, 0);
        chk("t4_drained", bus.count, 0);

        // flush beats simultaneous push and pop
        cyc(1, 16'h4040, 0, 0);
        cyc(1, 16'h4041, 0, 0);
        cyc(1, 16'h4042, 0, 0);
        chk("t5_count3", bus.count, 3);
        cyc(1, 16'h4043, 1, 1);
        chk("t5_flush_count", bus.count, 0);
        chk("t5_flush_valid", bus.out_valid, 0);
        chk("t5_flush_tag_err", bus.tag_err, 0);
        cyc(1, 16'h8000, 0, 1);
        chk("t5_flush_drop_tag_err", bus.tag_err, 0);
        cyc(1, 16'h4050, 0, 0);
        chk("t5_repush_valid", bus.out_valid, 1);
        chk("t5_repush_instr", bus.out_instr, 16'h4050);
        chk("t5_repush_count", bus.count, 1);
        cyc(0, 16'h0, 1, 0);
        chk("t5_drained", bus.count, 0);

        // empty FIFO, matching word with decode ready
        bus.in_valid = 1'b1;
        bus.in_data = 16'h4060;
        bus.out_ready = 1'b1;
        bus.flush = 1'b0;
        @(negedge clk);
        if (bus.in_ready) sb.push_back(16'h4060);
        #2;
`ifdef INSTR_REG_FALLTHROUGH_EN
        chk("t6_ft_valid_same", bus.out_valid, 1);
        chk("t6_ft_instr_same", bus.out_instr, 16'h4060);
        @(posedge clk);
        #1;
        chk("t6_ft_count", bus.count, 0);
        chk("t6_ft_valid_next", bus.out_valid, 0);
`else
        chk("t6_valid_same", bus.out_valid, 0);
        @(posedge clk);
        #1;
        chk("t6_valid_next", bus.out_valid, 1);
        chk("t6_count_next", bus.count, 1);
        cyc(0, 16'h0, 1, 0);
`endif
        chk("t6_drained", bus.count, 0);

        // asynchronous reset mid-operation
        cyc(1, 16'h4070, 0, 0);
        chk("t7_count_pre", bus.count, 1);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("t7_async_count", bus.count, 0);
        chk("t7_async_valid", bus.out_valid, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1, 16'h4071, 0, 0);
        chk("t7_post_rst_instr", bus.out_instr, 16'h4071);
        cyc(0, 16'h0, 1, 0);
        chk("t7_drained", bus.count, 0);

        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_reg_fifo.md
Name: instr_reg_fifo

Overview:
- Clocked, parametrised successor to the phase-gated instruction register.
- Accepts tagged instruction words from the fetch side and holds them in a DEPTH-entry FIFO. Only words whose tag field matches the current phase are written.
- Presents the head word to the decode stage with a valid/ready handshake.
- Replaces the single-word latch/C-element pair so fetch and decode can be decoupled by several instructions.

Parameters:
- WIDTH, 16, instruction word width in bits.
- TAG_W, 2, width of the phase tag held in in_data[WIDTH-1:WIDTH-TAG_W].
- DEPTH, 4, FIFO entries; power of 2, >= 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  instruction word; top TAG_W bits are the phase tag.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  FIFO can accept (= !full).
- phase  input  TAG_W  current phase code; compared against the tag.
- flush  input  1  synchronous discard of all held entries.
- out_instr  output  WIDTH  head-of-FIFO instruction, tag bits included.
- out_valid  output  1  out_instr is valid (= !empty).
- out_ready  input  1  decode accepts out_instr.
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- tag_err  output  1  one-cycle pulse: a handshaked word was rejected on tag mismatch.

Behaviour:
- Reset (rst_n=0, asynchronous): rd_ptr=wr_ptr=0, count=0, out_valid=0, out_instr=0, tag_err=0. Memory contents don't care.
- match = (in_data[WIDTH-1:WIDTH-TAG_W] == phase).
- in_ready = (count != DEPTH). It depends only on state, not on out_ready, so there is no combinational path from out_ready.
- Handshake: a word transfers when in_valid && in_ready. It transfers with match=1 as a push; with match=0 it is dropped. A drop asserts tag_err for exactly the following cycle, registered. The FIFO does not stall on a mismatch.
- pop = out_valid && out_ready.
- Latency: a word pushed at edge k is visible on out_instr with out_valid=1 after edge k, when the FIFO was empty.
- Order is strictly FIFO. out_instr = mem[rd_ptr] and stays stable while out_valid && !out_ready.
- Push and pop in the same cycle: both happen and count is unchanged. This is legal at count=DEPTH only as a pop, since in_ready=0 and no push occurs. At count=0 only a push occurs, since there is nothing to pop.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count: +1 on push only, -1 on pop only, otherwise held.
- flush=1 at an edge: pointers and count go to 0 and out_valid goes to 0. Push, pop and tag_err are suppressed that cycle, so flush has priority over every simultaneous event.
- Mid-operation reset clears all state immediately; the first legal push follows rst_n deassertion plus one edge.
- in_valid with in_ready=0: no effect, no tag_err. The upstream holds the word.

Optional Feature:
- Macro INSTR_REG_FALLTHROUGH_EN.
- Defined: when count=0 and in_valid && match, out_valid=1 and out_instr=in_data combinationally.
  - If out_ready=1 in that cycle, the word is consumed without being written and count stays 0.
  - If out_ready=0, it is pushed normally.
  - Zero-cycle latency through an empty FIFO.
- Undefined: out_instr/out_valid are driven only from FIFO state, with one-cycle minimum latency as above.

Test Plan:
- Reset then push 0x4001 with phase=2'b01, out_ready=0 -> next cycle out_valid=1, out_instr=0x4001, count=1, tag_err=0.
- Push 0x8123 with phase=2'b01 -> word dropped, count unchanged, tag_err=1 for exactly one cycle, in_ready stays 1.
- out_ready=0, push 5 matching words with DEPTH=4 -> count=4, in_ready=0 after 4th push, 5th held upstream. Then out_ready=1 -> words pop in order, and the 5th enters once in_ready=1.
- count=2, push and pop in the same cycle -> count remains 2, head advances, pushed word appears third. Run 3*DEPTH cycles to cover pointer wrap with no loss or reorder.
- count=3, assert flush with a simultaneous push and pop -> next cycle count=0, out_valid=0, no tag_err. The next push is seen with one-cycle latency.
- With INSTR_REG_FALLTHROUGH_EN, empty FIFO, in_valid=1, match, out_ready=1 -> out_valid=1 same cycle, out_instr=in_data, count stays 0. Without the macro, the same stimulus gives out_valid=0 that cycle and 1 the next.
